product_highlight_ctrl: RTL and testbench
=========================================

Name: product_highlight_ctrl

Overview:
- Sequences the product-grid highlight on the sale terminal display.
- Owns a navigation cursor over the 4x3 product grid and a browse/confirm state machine.
- Drives the 12-bit HighlightedProductList consumed by the image locator, with frame-synchronous updates and blinking in the confirm state.
- Emits a one-cycle selection event to the sale logic.

Parameters:
- GRID_COLS, 4, product columns (products numbered row-major, id = row*GRID_COLS + col)
- GRID_ROWS, 3, product rows
- NUM_PRODUCTS, 12, GRID_COLS*GRID_ROWS; width of HighlightedProductList
- BLINK_DIV, 12500000, clk cycles per blink half-period (0.5 s at 25 MHz)
- TIMEOUT_PERIODS, 20, blink half-periods without a button before returning to IDLE

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous, active-high reset
- btn_left  in  1  one-cycle pulse, already debounced
- btn_right  in  1  one-cycle pulse
- btn_up  in  1  one-cycle pulse
- btn_down  in  1  one-cycle pulse
- btn_select  in  1  one-cycle pulse
- btn_cancel  in  1  one-cycle pulse
- frame_start  in  1  one-cycle pulse at start of vertical blank
- HighlightedProductList  out  NUM_PRODUCTS  one-hot (or zero) highlight mask to the image locator
- cursor_id  out  4  current cursor product id
- selected_id  out  4  id of last confirmed product
- select_valid  out  1  one-cycle pulse; selected_id is valid in the same cycle
- ctrl_state  out  2  00 IDLE, 01 BROWSE, 10 CONFIRM

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. All state changes occur on the clk rising edge.
- Reset values: state IDLE, cursor_id 0, selected_id 0, select_valid 0, HighlightedProductList 0, shadow mask 0, blink counter 0, blink_phase 1, timeout counter 0.
- Reset asserted mid-operation forces all reset values on that edge. A pending select_valid is not emitted.
- Button priority: one event per cycle, in order cancel > select > left > right > up > down. Lower-priority pulses in the same cycle are dropped.
- Cursor arithmetic: col = cursor mod GRID_COLS, row = cursor / GRID_COLS.
  - left at col 0 wraps to col GRID_COLS-1; right at the last col wraps to 0; the row is unchanged in both cases.
  - up at row 0 wraps to row GRID_ROWS-1; down at the last row wraps to 0; the col is unchanged in both cases.
  - Cursor moves only in BROWSE.
- FSM:
  - IDLE: any direction button -> BROWSE, cursor unchanged (no move on that press). select and cancel are ignored. Shadow mask = 0.
  - BROWSE: a direction button moves the cursor. select -> CONFIRM. cancel -> IDLE. Shadow mask = one-hot(cursor).
  - CONFIRM: select -> select_valid = 1 for exactly one cycle with selected_id = cursor, then -> BROWSE. cancel -> BROWSE with no pulse. Direction buttons are ignored. Shadow mask = one-hot(cursor) when blink_phase = 1, else 0.
- Blink: the counter runs 0..BLINK_DIV-1, and blink_phase toggles on each wrap. Entering CONFIRM clears the counter and sets blink_phase = 1.
- Timeout:
  - The counter increments on each blink wrap while in BROWSE or CONFIRM. It clears on any accepted or ignored button pulse and on entering IDLE.
  - On reaching TIMEOUT_PERIODS, the state goes to IDLE. A button arriving in the same cycle takes precedence; the timeout is discarded.
- Output timing:
  - The shadow mask is combinational from the registered state. HighlightedProductList loads the shadow only on frame_start, and holds otherwise.
  - A frame_start in the same cycle as a state change loads the pre-change mask. The new mask appears at the next frame_start.
- cursor_id and ctrl_state are registered and update one edge after the event, independent of frame_start.
- selected_id holds its value until the next confirm.

Test Plan (BLINK_DIV=4, TIMEOUT_PERIODS=3):
- Reset: hold rst 2 cycles mid-CONFIRM -> ctrl_state=00, cursor_id=0, HighlightedProductList=0 after the next frame_start, select_valid never 1.
- Wrap: from IDLE press right (enter BROWSE), then left -> cursor 3. Press up -> cursor 11. Press down -> cursor 3. Then a frame_start -> HighlightedProductList=12'h008.
- Confirm: cursor 5, select, select -> exactly one cycle of select_valid=1 with selected_id=5, ctrl_state returns to 01. With cancel instead of the second select -> no pulse, ctrl_state=01.
- Blink and frame sync: in CONFIRM at cursor 5, pulse frame_start every 2 cycles -> mask alternates 12'h020 / 12'h000 every 4 cycles, starting with 12'h020. The mask never changes between frame_start pulses.
- Priority: assert btn_cancel+btn_select+btn_right together in BROWSE -> ctrl_state=00, cursor unchanged, no select_valid.
- Timeout: enter BROWSE, no buttons for 12 cycles -> ctrl_state=00 after the 3rd blink wrap. Repeat with a btn_down at cycle 11 -> stays in BROWSE and the timeout counter is cleared.

Source files
------------

// File: rtl/product_highlight_ctrl_if.sv
// rtl/product_highlight_ctrl_if.sv - button/frame inputs and highlight outputs of the product highlight controller
//
// Signals:
//   btn_left/right/up/down/select/cancel  debounced one-cycle button pulses
//   frame_start                           one-cycle pulse at start of vertical blank
//   HighlightedProductList                one-hot (or zero) highlight mask
//   cursor_id, selected_id                current cursor / last confirmed product id
//   select_valid                          one-cycle selection event
//   ctrl_state                            00 IDLE, 01 BROWSE, 10 CONFIRM
// Modports: master drives buttons/frame_start, slave is the controller.
interface product_highlight_ctrl_if #(
    parameter int NUM_PRODUCTS = 12
);
    logic                    btn_left;
    logic                    btn_right;
    logic                    btn_up;
    logic                    btn_down;
    logic                    btn_select;
    logic                    btn_cancel;
    logic                    frame_start;
    logic [NUM_PRODUCTS-1:0] HighlightedProductList;
    logic [3:0]              cursor_id;
    logic [3:0]              selected_id;
    logic                    select_valid;
    logic [1:0]              ctrl_state;

    modport master (
        output btn_left, btn_right, btn_up, btn_down, btn_select, btn_cancel, frame_start,
        input  HighlightedProductList, cursor_id, selected_id, select_valid, ctrl_state
    );

    modport slave (
        input  btn_left, btn_right, btn_up, btn_down, btn_select, btn_cancel, frame_start,
        output HighlightedProductList, cursor_id, selected_id, select_valid, ctrl_state
    );
endinterface

// File: rtl/product_highlight_ctrl.sv
// rtl/product_highlight_ctrl.sv - product-grid highlight sequencer with browse/confirm FSM
//
// Ports:
//   clk  system/pixel clock
//   rst  synchronous, active-high reset
//   bus  product_highlight_ctrl_if.slave: buttons and frame_start in;
//        HighlightedProductList, cursor_id, selected_id, select_valid, ctrl_state out
module product_highlight_ctrl #(
    parameter int GRID_COLS       = 4,
    parameter int GRID_ROWS       = 3,
    parameter int NUM_PRODUCTS    = GRID_COLS * GRID_ROWS,
    parameter int BLINK_DIV       = 12500000,
    parameter int TIMEOUT_PERIODS = 20
) (
    input logic                     clk,
    input logic                     rst,
    product_highlight_ctrl_if.slave bus
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_PERIODS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BROWSE  = 2'b01,
        CONFIRM = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cursor_q, cursor_d;
    logic [3:0]              selected_q, selected_d;
    logic                    sel_valid_q, sel_valid_d;
    logic [NUM_PRODUCTS-1:0] hpl_q, hpl_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [TW-1:0]           tmo_q, tmo_d;

    logic [3:0]              col, row;
    logic [3:0]              cur_left, cur_right, cur_up, cur_down;
    logic                    ev_cancel, ev_select, ev_left, ev_right, ev_up, ev_down, ev_dir;
    logic                    any_btn, wrap, timeout_hit;
    logic [NUM_PRODUCTS-1:0] onehot, shadow;

    assign col = 4'(int'(cursor_q) % GRID_COLS);
    assign row = 4'(int'(cursor_q) / GRID_COLS);

    // Horizontal moves wrap within the row, vertical moves wrap within the column.
    assign cur_left  = (col == 4'd0) ? 4'(int'(row) * GRID_COLS + GRID_COLS - 1) : cursor_q - 4'd1;
    assign cur_right = (col == 4'(GRID_COLS - 1)) ? 4'(int'(row) * GRID_COLS) : cursor_q + 4'd1;
    assign cur_up    = (row == 4'd0) ? 4'((GRID_ROWS - 1) * GRID_COLS + int'(col))
                                     : 4'(int'(cursor_q) - GRID_COLS);
    assign cur_down  = (row == 4'(GRID_ROWS - 1)) ? col : 4'(int'(cursor_q) + GRID_COLS);

    // One event per cycle: cancel > select > left > right > up > down.
    assign ev_cancel = bus.btn_cancel;
    assign ev_select = !bus.btn_cancel && bus.btn_select;
    assign ev_left   = !bus.btn_cancel && !bus.btn_select && bus.btn_left;
    assign ev_right  = !bus.btn_cancel && !bus.btn_select && !bus.btn_left && bus.btn_right;
    assign ev_up     = !bus.btn_cancel && !bus.btn_select && !bus.btn_left && !bus.btn_right
                       && bus.btn_up;
    assign ev_down   = !bus.btn_cancel && !bus.btn_select && !bus.btn_left && !bus.btn_right
                       && !bus.btn_up && bus.btn_down;
    assign ev_dir    = ev_left || ev_right || ev_up || ev_down;
    assign any_btn   = bus.btn_cancel || bus.btn_select || bus.btn_left || bus.btn_right
                       || bus.btn_up || bus.btn_down;

    assign wrap        = (blink_cnt_q == BW'(BLINK_DIV - 1));
    // The counter reaches TIMEOUT_PERIODS on this wrap; a button in the same cycle wins.
    assign timeout_hit = (state_q != IDLE) && wrap && (tmo_q == TW'(TIMEOUT_PERIODS - 1))
                         && !any_btn;

    assign onehot = NUM_PRODUCTS'(1) << cursor_q;

    always_comb begin
        shadow = '0;
        case (state_q)
            BROWSE:  shadow = onehot;
            CONFIRM: shadow = blink_phase_q ? onehot : '0;
            default: shadow = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        selected_d    = selected_q;
        sel_valid_d   = 1'b0;
        blink_cnt_d   = wrap ? '0 : blink_cnt_q + BW'(1);
        blink_phase_d = wrap ? !blink_phase_q : blink_phase_q;
        tmo_d         = tmo_q;
        // Mask only follows the shadow at frame_start so the image never tears mid-frame.
        hpl_d         = bus.frame_start ? shadow : hpl_q;

        if (wrap && state_q != IDLE) begin
            tmo_d = tmo_q + TW'(1);
        end
        if (any_btn) begin
            tmo_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (ev_dir) begin
                    state_d = BROWSE;
                end
            end
            BROWSE: begin
                if (ev_cancel) begin
                    state_d = IDLE;
                end else if (ev_select) begin
                    state_d       = CONFIRM;
                    blink_cnt_d   = '0;
                    blink_phase_d = 1'b1;
                end else if (ev_left) begin
                    cursor_d = cur_left;
                end else if (ev_right) begin
                    cursor_d = cur_right;
                end else if (ev_up) begin
                    cursor_d = cur_up;
                end else if (ev_down) begin
                    cursor_d = cur_down;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            CONFIRM: begin
                if (ev_cancel) begin
                    state_d = BROWSE;
                end else if (ev_select) begin
                    state_d     = BROWSE;
                    sel_valid_d = 1'b1;
                    selected_d  = cursor_q;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cursor_q      <= '0;
            selected_q    <= '0;
            sel_valid_q   <= 1'b0;
            hpl_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            selected_q    <= selected_d;
            sel_valid_q   <= sel_valid_d;
            hpl_q         <= hpl_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            tmo_q         <= tmo_d;
        end
    end

    assign bus.HighlightedProductList = hpl_q;
    assign bus.cursor_id              = cursor_q;
    assign bus.selected_id            = selected_q;
    assign bus.select_valid           = sel_valid_q;
    assign bus.ctrl_state             = state_q;

endmodule

// File: tb/tb_product_highlight_ctrl.sv
// tb/tb_product_highlight_ctrl.sv - scoreboard testbench for product_highlight_ctrl
module tb_product_highlight_ctrl;

    localparam logic [5:0] B_C = 6'b100000;
    localparam logic [5:0] B_S = 6'b010000;
    localparam logic [5:0] B_L = 6'b001000;
    localparam logic [5:0] B_R = 6'b000100;
    localparam logic [5:0] B_U = 6'b000010;
    localparam logic [5:0] B_D = 6'b000001;

    localparam int F_STATE = 0;
    localparam int F_CUR   = 1;
    localparam int F_HPL   = 2;
    localparam int F_SEL   = 3;
    localparam int F_SV    = 4;

    typedef struct {
        int          cyc;
        int          field;
        logic [11:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t       chk_q[$];
    logic [3:0] sel_q[$];

    product_highlight_ctrl_if #(.NUM_PRODUCTS(12)) bus ();

    product_highlight_ctrl #(
        .GRID_COLS(4),
        .GRID_ROWS(3),
        .NUM_PRODUCTS(12),
        .BLINK_DIV(4),
        .TIMEOUT_PERIODS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = !clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] actual(input int f);
        case (f)
            F_STATE: return {10'd0, bus.ctrl_state};
            F_CUR:   return {8'd0, bus.cursor_id};
            F_HPL:   return bus.HighlightedProductList;
            F_SEL:   return {8'd0, bus.selected_id};
            default: return {11'd0, bus.select_valid};
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_STATE: return "ctrl_state";
            F_CUR:   return "cursor_id";
            F_HPL:   return "HighlightedProductList";
            F_SEL:   return "selected_id";
            default: return "select_valid";
        endcase
    endfunction

    // Monitor: selection pulses are matched against the selection queue, state
    // snapshots against the expectation queue tagged with the edge they follow.
    always @(negedge clk) begin
        if (bus.select_valid === 1'b1) begin
            n_checks++;
            if (sel_q.size() == 0) begin
                n_fail++;
                $display("FAIL select_pulse @%0d: got select_valid=1 selected_id=%0d, required no pulse",
                         cyc, bus.selected_id);
            end else begin
                automatic logic [3:0] e = sel_q.pop_front();
                if (bus.selected_id !== e) begin
                    n_fail++;
                    $display("FAIL select_id @%0d: got %0d, required %0d", cyc, bus.selected_id, e);
                end
            end
        end
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            automatic exp_t e = chk_q.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL stale_%s: expectation for edge %0d reached at %0d", fname(e.field), e.cyc, cyc);
            end else if (actual(e.field) !== e.val) begin
                n_fail++;
                $display("FAIL %s @%0d: got 0x%03h, required 0x%03h", fname(e.field), cyc,
                         actual(e.field), e.val);
            end
        end
    end

    task automatic tick(input logic [5:0] b, input logic fs, input logic r);
        @(negedge clk);
        rst             = r;
        bus.btn_cancel  = b[5];
        bus.btn_select  = b[4];
        bus.btn_left    = b[3];
        bus.btn_right   = b[2];
        bus.btn_up      = b[1];
        bus.btn_down    = b[0];
        bus.frame_start = fs;
    endtask

    task automatic chk(input int f, input logic [11:0] v);
        chk_q.push_back('{cyc + 1, f, v});
    endtask

    logic [11:0] blink_exp [10];

    initial begin
        bus.btn_cancel = 0; bus.btn_select = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.btn_up = 0; bus.btn_down = 0; bus.frame_start = 0;
        blink_exp = '{12'h020, 12'h020, 12'h020, 12'h020, 12'h000,
                      12'h000, 12'h000, 12'h000, 12'h020, 12'h020};

        // Reset values
        tick(6'd0, 0, 1);
        tick(6'd0, 0, 1);
        chk(F_STATE, 0); chk(F_CUR, 0); chk(F_HPL, 0); chk(F_SEL, 0); chk(F_SV, 0);

        // Wrap
        tick(B_R, 0, 0); chk(F_STATE, 1); chk(F_CUR, 0); chk(F_HPL, 0);
        tick(B_L, 0, 0); chk(F_CUR, 3);
        tick(B_U, 0, 0); chk(F_CUR, 11);
        tick(B_D, 0, 0); chk(F_CUR, 3); chk(F_HPL, 0);
        tick(6'd0, 1, 0); chk(F_HPL, 12'h008);
        tick(6'd0, 0, 0); chk(F_HPL, 12'h008);

        // Confirm with second select, then with cancel
        tick(B_R, 0, 0); chk(F_CUR, 0);
        tick(B_D, 0, 0); chk(F_CUR, 4);
        tick(B_R, 0, 0); chk(F_CUR, 5);
        tick(B_S, 0, 0); chk(F_STATE, 2);
        tick(B_S, 0, 0); sel_q.push_back(4'd5);
        chk(F_STATE, 1); chk(F_SV, 1); chk(F_SEL, 5);
        tick(6'd0, 0, 0); chk(F_SV, 0); chk(F_SEL, 5); chk(F_STATE, 1);
        tick(B_S, 0, 0); chk(F_STATE, 2);
        tick(B_C, 0, 0); chk(F_STATE, 1); chk(F_SV, 0);
        tick(6'd0, 0, 0); chk(F_SV, 0); chk(F_SEL, 5);

        // Blink and frame sync in CONFIRM at cursor 5
        tick(B_S, 0, 0); chk(F_STATE, 2);
        for (int i = 1; i <= 10; i++) begin
            tick(6'd0, (i % 2) == 1, 0);
            chk(F_HPL, blink_exp[i-1]);
        end
        chk(F_STATE, 2);

        // Reset mid-CONFIRM, coinciding with a select
        tick(B_S, 0, 1);
        tick(6'd0, 0, 1); chk(F_STATE, 0); chk(F_CUR, 0); chk(F_HPL, 0); chk(F_SEL, 0);
        tick(6'd0, 1, 0); chk(F_HPL, 0); chk(F_STATE, 0); chk(F_SV, 0);

        // Priority
        tick(B_R, 0, 0); chk(F_STATE, 1);
        tick(B_D, 0, 0); chk(F_CUR, 4);
        tick(B_C | B_S | B_R, 0, 0); chk(F_STATE, 0); chk(F_CUR, 4);

        // Timeout with no buttons
        tick(6'd0, 0, 1);
        tick(B_R, 0, 0); chk(F_STATE, 1);
        for (int i = 0; i < 10; i++) tick(6'd0, 0, 0);
        chk(F_STATE, 1);
        tick(6'd0, 0, 0); chk(F_STATE, 0);

        // Timeout discarded by a coincident button, then counted afresh
        tick(6'd0, 0, 1);
        tick(B_R, 0, 0); chk(F_STATE, 1);
        for (int i = 0; i < 10; i++) tick(6'd0, 0, 0);
        tick(B_D, 0, 0); chk(F_STATE, 1); chk(F_CUR, 4);
        for (int i = 0; i < 11; i++) tick(6'd0, 0, 0);
        chk(F_STATE, 1);
        tick(6'd0, 0, 0); chk(F_STATE, 0);

        tick(6'd0, 0, 0);
        tick(6'd0, 0, 0);
        @(negedge clk);
        #1;
        n_checks++;
        if (chk_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_checks: %0d left, required 0", chk_q.size());
        end
        n_checks++;
        if (sel_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_select: %0d expected pulses not seen, required 0", sel_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
